dw_conv_mac_array: RTL and testbench
====================================

Name: dw_conv_mac_array

Overview:
- Depthwise 3x3 compute stage directly downstream of the depthwise pre-process block (row buffer plus window generator).
- Consumes one flattened 3x3 window per channel per valid cycle and applies a per-channel 3x3 kernel plus bias.
- Requantizes the result, with optional ReLU, to DATA_WIDTH signed per channel.
- Per-channel weights and biases load serially into a shadow bank, which is committed atomically, so windows already in flight are never corrupted.

Parameters:
- DATA_WIDTH, 8: signed activation/weight width.
- OUT_CHANNEL_NUM, 18: parallel channels; matches the upstream window generator.
- IN_CHANNEL_NUM, 9: taps per window (3x3); fixed at 9.
- BIAS_WIDTH, 16: signed per-channel bias width.
- ACC_WIDTH, 24: signed accumulator width.
- SHIFT_WIDTH, 5: requant shift amount width.

Ports:
- clk, input, 1: system clock.
- rstn, input, 1: asynchronous active-low reset.
- win_in, input, OUT_CHANNEL_NUM*IN_CHANNEL_NUM*DATA_WIDTH: windows. Channel c, tap k sits at [(c*9+k)*DATA_WIDTH +: DATA_WIDTH].
- valid_in, input, 1: win_in valid this cycle.
- data_out, output, OUT_CHANNEL_NUM*DATA_WIDTH: requantized result. Channel c sits at [c*DATA_WIDTH +: DATA_WIDTH].
- valid_out, output, 1: data_out valid.
- wt_load_start, input, 1: 1-cycle pulse; begins shadow load.
- wt_data, input, BIAS_WIDTH+9*DATA_WIDTH: one channel per word = {bias, w8..w0}, with w0 at the LSBs.
- wt_valid, input, 1: wt_data valid.
- shift_amt, input, SHIFT_WIDTH: right-shift for requant; quasi-static.
- relu_en, input, 1: clamp negatives to 0; quasi-static.
- wt_ready, output, 1: active bank holds a committed kernel set.
- err_drop, output, 1: sticky flag; a window arrived with no committed weights.

Behaviour:
- Reset values:
  - All pipeline registers, data_out, valid_out, wt_ready, err_drop = 0.
  - Both weight banks = 0.
  - FSM = IDLE, channel counter = 0.
- Load FSM states: IDLE, LOAD, COMMIT.
  - IDLE --wt_load_start--> LOAD, with ch_cnt = 0.
  - LOAD: each wt_valid writes the word into shadow[ch_cnt] and increments ch_cnt.
  - LOAD: the write with ch_cnt = OUT_CHANNEL_NUM-1 goes to COMMIT.
  - COMMIT (1 cycle): active <= shadow, wt_ready <= 1, then -> IDLE.
  - wt_load_start during LOAD restarts: ch_cnt = 0, shadow contents are kept but will be overwritten.
  - wt_load_start in the same cycle as the final wt_valid: the restart wins and no commit occurs.
  - wt_valid in IDLE or COMMIT is ignored.
- Windows are accepted only when wt_ready = 1.
  - valid_in with wt_ready = 0 produces no valid_out and sets err_drop. err_drop clears only on reset.
  - During LOAD, windows use the old active bank. After COMMIT they use the new bank.
  - A window entering in the COMMIT cycle uses the old bank; the copy lands at the end of that cycle.
- Datapath, per channel, fully pipelined, 1 window/cycle, no backpressure, fixed latency 4:
  - S1: nine signed DATA_WIDTH x DATA_WIDTH products, each 2*DATA_WIDTH wide, registered.
  - S2: three partial sums of taps {0,1,2}, {3,4,5}, {6,7,8}, sign-extended to ACC_WIDTH, registered.
  - S3: sum of the partials + sign-extended bias, registered.
  - S4: rounding and output clamp, registered as data_out:
    - If shift_amt > 0, add 1<<(shift_amt-1).
    - Arithmetic right shift by shift_amt.
    - If relu_en, negatives become 0.
    - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- valid_out is valid_in (gated by wt_ready) delayed 4 cycles. data_out holds its last value when valid_out = 0.
- Bank capture: the weight/bias values used by a window are those in the active bank in the cycle the window enters S1.
  - The bias is carried alongside the window, so no mixed-bank result is possible.
- Asynchronous reset mid-operation:
  - Flushes the pipeline; no valid_out follows.
  - Clears both banks and wt_ready.

Test Plan:
- Reset then valid_in pulse, no load:
  - valid_out stays 0 and err_drop = 1.
  - err_drop stays 1 through 20 idle cycles.
- Load 18 words (all weights 1, bias 0), shift_amt 0, relu_en 0; window taps 1..9 on every channel:
  - wt_ready rises the cycle after COMMIT.
  - Exactly 4 cycles after valid_in, every channel = 45 with valid_out = 1 for 1 cycle.
- Same weights, taps all 127, bias 100:
  - Sum = 1243, saturates to 127.
  - Taps all -128, bias 0: sum = -1152, saturates to -128; with relu_en = 1 the result is 0.
- Rounding: weights 1, bias 0, taps 1..9 (sum 45):
  - shift_amt 2 gives (45+2)>>2 = 11.
  - Sum -45 (taps negated): (-45+2)>>>2 = -11.
- Back-to-back windows on 10 consecutive cycles:
  - valid_out high on 10 consecutive cycles starting 4 cycles later, in matching order.
  - Per-channel distinct weights (channel c: w = c+1) give channel c = 45*(c+1), saturated at 127.
- Reload while streaming: bank A (w = 1) committed, then a new load of w = 2 starts while windows stream:
  - Windows before and during COMMIT produce 45.
  - Windows after COMMIT produce 90.
  - A wt_load_start at word 10 restarts the count and needs a full 18 more words before commit.

Source files
------------

// File: rtl/dw_conv_mac_array.sv
// Depthwise 3x3 MAC array: per-channel kernel + bias, 4-stage pipeline, requant/ReLU/saturate.
// Weights load serially into a shadow bank and are committed to the active bank in one cycle.
module dw_conv_mac_array #(
    parameter int DATA_WIDTH      = 8,
    parameter int OUT_CHANNEL_NUM = 18,
    parameter int IN_CHANNEL_NUM  = 9,
    parameter int BIAS_WIDTH      = 16,
    parameter int ACC_WIDTH       = 24,
    parameter int SHIFT_WIDTH     = 5
) (
    input  logic                                               clk,
    input  logic                                               rstn,
    input  logic [OUT_CHANNEL_NUM*IN_CHANNEL_NUM*DATA_WIDTH-1:0] win_in,
    input  logic                                               valid_in,
    output logic [OUT_CHANNEL_NUM*DATA_WIDTH-1:0]              data_out,
    output logic                                               valid_out,
    input  logic                                               wt_load_start,
    input  logic [BIAS_WIDTH+IN_CHANNEL_NUM*DATA_WIDTH-1:0]    wt_data,
    input  logic                                               wt_valid,
    input  logic [SHIFT_WIDTH-1:0]                             shift_amt,
    input  logic                                               relu_en,
    output logic                                               wt_ready,
    output logic                                               err_drop
);
    // state  | meaning
    // IDLE   | no load in progress
    // LOAD   | writing wt_data words into shadow[ch_cnt]
    // COMMIT | copy shadow -> active, raise wt_ready
    typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

    localparam int WORD_W = BIAS_WIDTH + IN_CHANNEL_NUM * DATA_WIDTH;
    localparam int CW     = $clog2(OUT_CHANNEL_NUM);
    localparam int PW     = 2 * DATA_WIDTH;
    // Wide enough that any shift amount and its rounding constant never overflow.
    localparam int EW     = ACC_WIDTH + 2 ** SHIFT_WIDTH;
    localparam logic signed [EW-1:0] SAT_MAX = EW'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [EW-1:0] SAT_MIN = ~SAT_MAX;

    state_t               state_q, state_d;
    logic [CW-1:0]        ch_cnt_q, ch_cnt_d;
    logic                 shadow_we, commit;
    logic [WORD_W-1:0]    shadow_q [OUT_CHANNEL_NUM];
    logic [WORD_W-1:0]    active_q [OUT_CHANNEL_NUM];
    logic                 wt_ready_q, err_drop_q, accept;

    logic                 v1_q, v2_q, v3_q, valid_out_q;
    logic signed [PW-1:0]         prod_q  [OUT_CHANNEL_NUM][IN_CHANNEL_NUM];
    logic signed [BIAS_WIDTH-1:0] bias1_q [OUT_CHANNEL_NUM];
    logic signed [BIAS_WIDTH-1:0] bias2_q [OUT_CHANNEL_NUM];
    logic signed [ACC_WIDTH-1:0]  part_q  [OUT_CHANNEL_NUM][3];
    logic signed [ACC_WIDTH-1:0]  sum_q   [OUT_CHANNEL_NUM];
    logic [OUT_CHANNEL_NUM*DATA_WIDTH-1:0] data_out_q;

    function automatic logic [DATA_WIDTH-1:0] requant(input logic signed [ACC_WIDTH-1:0] s,
                                                       input logic [SHIFT_WIDTH-1:0] sh,
                                                       input logic relu);
        logic signed [EW-1:0] t, rnd;
        rnd = '0;
        if (sh != '0) rnd = {{(EW-1){1'b0}}, 1'b1} << (sh - 1'b1);
        t = EW'(s) + rnd;
        t = t >>> sh;
        if (relu && t[EW-1]) t = '0;
        if (t > SAT_MAX)      t = SAT_MAX;
        else if (t < SAT_MIN) t = SAT_MIN;
        return t[DATA_WIDTH-1:0];
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            ch_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            ch_cnt_q <= ch_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ch_cnt_d  = ch_cnt_q;
        shadow_we = 1'b0;
        commit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (wt_load_start) begin
                    state_d  = LOAD;
                    ch_cnt_d = '0;
                end
            end
            LOAD: begin
                // A restart wins over a coincident word, including the final one.
                if (wt_load_start) begin
                    ch_cnt_d = '0;
                end else if (wt_valid) begin
                    shadow_we = 1'b1;
                    if (ch_cnt_q == CW'(OUT_CHANNEL_NUM - 1)) state_d = COMMIT;
                    else ch_cnt_d = ch_cnt_q + 1'b1;
                end
            end
            COMMIT: begin
                commit  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < OUT_CHANNEL_NUM; c++) begin
                shadow_q[c] <= '0;
                active_q[c] <= '0;
            end
            wt_ready_q <= 1'b0;
            err_drop_q <= 1'b0;
        end else begin
            if (shadow_we) shadow_q[ch_cnt_q] <= wt_data;
            if (commit) begin
                active_q   <= shadow_q;
                wt_ready_q <= 1'b1;
            end
            if (valid_in && !wt_ready_q) err_drop_q <= 1'b1;
        end
    end

    assign accept = valid_in & wt_ready_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            for (int c = 0; c < OUT_CHANNEL_NUM; c++) begin
                for (int k = 0; k < IN_CHANNEL_NUM; k++) prod_q[c][k] <= '0;
                for (int j = 0; j < 3; j++) part_q[c][j] <= '0;
                bias1_q[c] <= '0;
                bias2_q[c] <= '0;
                sum_q[c]   <= '0;
            end
        end else begin
            v1_q        <= accept;
            v2_q        <= v1_q;
            v3_q        <= v2_q;
            valid_out_q <= v3_q;
            for (int c = 0; c < OUT_CHANNEL_NUM; c++) begin
                // Bias travels with the window so the whole result uses one bank.
                if (accept) begin
                    for (int k = 0; k < IN_CHANNEL_NUM; k++)
                        prod_q[c][k] <= PW'($signed(win_in[(c*IN_CHANNEL_NUM+k)*DATA_WIDTH +: DATA_WIDTH]))
                                      * PW'($signed(active_q[c][k*DATA_WIDTH +: DATA_WIDTH]));
                    bias1_q[c] <= active_q[c][IN_CHANNEL_NUM*DATA_WIDTH +: BIAS_WIDTH];
                end
                if (v1_q) begin
                    for (int j = 0; j < 3; j++)
                        part_q[c][j] <= ACC_WIDTH'(prod_q[c][3*j]) + ACC_WIDTH'(prod_q[c][3*j+1])
                                      + ACC_WIDTH'(prod_q[c][3*j+2]);
                    bias2_q[c] <= bias1_q[c];
                end
                if (v2_q)
                    sum_q[c] <= part_q[c][0] + part_q[c][1] + part_q[c][2] + ACC_WIDTH'(bias2_q[c]);
                if (v3_q)
                    data_out_q[c*DATA_WIDTH +: DATA_WIDTH] <= requant(sum_q[c], shift_amt, relu_en);
            end
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign wt_ready  = wt_ready_q;
    assign err_drop  = err_drop_q;

endmodule

// File: tb/tb_dw_conv_mac_array.sv
// Scoreboard bench for dw_conv_mac_array: expected results (with arrival cycle) are queued
// when windows are driven and compared against outputs recorded by a negedge monitor.
module tb_dw_conv_mac_array;
    localparam int DW = 8, N = 18, T = 9, BW = 16, SW = 5;
    localparam int WIN_W = N*T*DW, OW = N*DW, WW = BW+T*DW;

    logic clk, rstn, valid_in, valid_out, wt_load_start, wt_valid, relu_en, wt_ready, err_drop;
    logic [WIN_W-1:0] win_in;
    logic [OW-1:0]    data_out;
    logic [WW-1:0]    wt_data;
    logic [SW-1:0]    shift_amt;

    dw_conv_mac_array dut (
        .clk(clk), .rstn(rstn), .win_in(win_in), .valid_in(valid_in),
        .data_out(data_out), .valid_out(valid_out), .wt_load_start(wt_load_start),
        .wt_data(wt_data), .wt_valid(wt_valid), .shift_amt(shift_amt), .relu_en(relu_en),
        .wt_ready(wt_ready), .err_drop(err_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int cyc; logic [OW-1:0] d;} rec_t;
    rec_t exp_q[$];
    rec_t obs_q[$];
    rec_t mon_r;
    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            mon_r.cyc = cyc;
            mon_r.d   = data_out;
            obs_q.push_back(mon_r);
        end
    end

    int errors = 0;
    int checks = 0;
    int cur_w[N][T];
    int cur_b[N];
    int ld_w[N][T];
    int ld_b[N];
    int tv[T];

    function automatic logic [OW-1:0] model(input logic [WIN_W-1:0] win);
        logic [OW-1:0] r;
        longint acc, x;
        for (int c = 0; c < N; c++) begin
            acc = cur_b[c];
            for (int k = 0; k < T; k++) begin
                x = $signed(win[(c*T+k)*DW +: DW]);
                acc += longint'(cur_w[c][k]) * x;
            end
            if (shift_amt > 0) acc += longint'(1) << (shift_amt - 1);
            acc = acc >>> shift_amt;
            if (relu_en && acc < 0) acc = 0;
            if (acc > 127) acc = 127;
            if (acc < -128) acc = -128;
            r[c*DW +: DW] = acc[DW-1:0];
        end
        return r;
    endfunction

    function automatic logic [WW-1:0] pack_word(input int c);
        logic [WW-1:0] p;
        int v;
        for (int k = 0; k < T; k++) begin
            v = ld_w[c][k];
            p[k*DW +: DW] = v[DW-1:0];
        end
        v = ld_b[c];
        p[T*DW +: BW] = v[BW-1:0];
        return p;
    endfunction

    function automatic logic [WIN_W-1:0] mk_win();
        logic [WIN_W-1:0] w;
        int v;
        for (int c = 0; c < N; c++)
            for (int k = 0; k < T; k++) begin
                v = tv[k];
                w[(c*T+k)*DW +: DW] = v[DW-1:0];
            end
        return w;
    endfunction

    // Called right after a negedge: present a window and queue its expected result.
    task automatic push_win();
        rec_t e;
        win_in   = mk_win();
        valid_in = 1'b1;
        e.cyc    = cyc + 4;
        e.d      = model(win_in);
        exp_q.push_back(e);
    endtask

    task automatic set_ld(input int wmode, input int bias);
        for (int c = 0; c < N; c++) begin
            for (int k = 0; k < T; k++) ld_w[c][k] = (wmode == 0) ? 1 : (wmode == 1) ? 2 : c + 1;
            ld_b[c] = bias;
        end
    endtask

    task automatic load_bank(output logic rdy_commit, output logic rdy_after);
        @(negedge clk);
        valid_in = 1'b0; wt_load_start = 1'b1; wt_valid = 1'b0;
        for (int c = 0; c < N; c++) begin
            @(negedge clk);
            wt_load_start = 1'b0; wt_valid = 1'b1; wt_data = pack_word(c);
        end
        @(negedge clk);
        wt_valid   = 1'b0;
        rdy_commit = wt_ready;
        @(negedge clk);
        rdy_after  = wt_ready;
        cur_w = ld_w;
        cur_b = ld_b;
    endtask

    task automatic test_reset();
        rstn = 1'b0; valid_in = 1'b0; wt_load_start = 1'b0; wt_valid = 1'b0;
        win_in = '0; wt_data = '0; shift_amt = '0; relu_en = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out: got %b want 0", valid_out); end
        checks++; if (wt_ready !== 1'b0) begin errors++; $display("FAIL reset_wt_ready: got %b want 0", wt_ready); end
        checks++; if (err_drop !== 1'b0) begin errors++; $display("FAIL reset_err_drop: got %b want 0", err_drop); end
        checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data_out: got %h want 0", data_out); end
    endtask

    task automatic test_no_weights();
        obs_q.delete();
        @(negedge clk);
        for (int k = 0; k < T; k++) tv[k] = k + 1;
        win_in = mk_win(); valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        checks++; if (err_drop !== 1'b1) begin errors++; $display("FAIL drop_err_set: got %b want 1", err_drop); end
        repeat (6) @(negedge clk);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL drop_no_output: got %0d outputs want 0", obs_q.size()); end
        repeat (20) @(negedge clk);
        checks++; if (err_drop !== 1'b1) begin errors++; $display("FAIL drop_err_sticky: got %b want 1", err_drop); end
        obs_q.delete();
    endtask

    task automatic test_load();
        logic r0, r1;
        rec_t e, o;
        set_ld(0, 0);
        load_bank(r0, r1);
        checks++; if (r0 !== 1'b0) begin errors++; $display("FAIL load_ready_commit: got %b want 0", r0); end
        checks++; if (r1 !== 1'b1) begin errors++; $display("FAIL load_ready_after: got %b want 1", r1); end
        @(negedge clk);
        for (int k = 0; k < T; k++) tv[k] = k + 1;
        push_win();
        @(negedge clk);
        valid_in = 1'b0;
        repeat (8) @(negedge clk);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL load_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL load_missing: want cyc %0d data %h", e.cyc, e.d); end
            else begin
                o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.d !== e.d) begin errors++; $display("FAIL load_data: got cyc %0d %h want cyc %0d %h", o.cyc, o.d, e.cyc, e.d); end
            end
        end
        obs_q.delete();
    endtask

    task automatic test_saturation();
        logic r0, r1;
        rec_t e, o;
        set_ld(0, 100);
        load_bank(r0, r1);
        for (int pass = 0; pass < 2; pass++) begin
            relu_en = (pass == 1);
            if (pass == 0) begin
                @(negedge clk);
                for (int k = 0; k < T; k++) tv[k] = 127;
                push_win();
            end
            @(negedge clk);
            for (int k = 0; k < T; k++) tv[k] = -128;
            push_win();
            @(negedge clk);
            valid_in = 1'b0;
            repeat (8) @(negedge clk);
            checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL sat_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front(); checks++;
                if (obs_q.size() == 0) begin errors++; $display("FAIL sat_missing: want cyc %0d data %h", e.cyc, e.d); end
                else begin
                    o = obs_q.pop_front();
                    if (o.cyc !== e.cyc || o.d !== e.d) begin errors++; $display("FAIL sat_data: got cyc %0d %h want cyc %0d %h", o.cyc, o.d, e.cyc, e.d); end
                end
            end
            obs_q.delete();
        end
        relu_en = 1'b0;
    endtask

    task automatic test_rounding();
        logic r0, r1;
        rec_t e, o;
        set_ld(0, 0);
        load_bank(r0, r1);
        shift_amt = 5'd2;
        @(negedge clk);
        for (int k = 0; k < T; k++) tv[k] = k + 1;
        push_win();
        @(negedge clk);
        for (int k = 0; k < T; k++) tv[k] = -(k + 1);
        push_win();
        @(negedge clk);
        valid_in = 1'b0;
        repeat (8) @(negedge clk);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL round_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL round_missing: want cyc %0d data %h", e.cyc, e.d); end
            else begin
                o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.d !== e.d) begin errors++; $display("FAIL round_data: got cyc %0d %h want cyc %0d %h", o.cyc, o.d, e.cyc, e.d); end
            end
        end
        obs_q.delete();
        shift_amt = '0;
    endtask

    task automatic test_back_to_back();
        logic r0, r1;
        rec_t e, o;
        set_ld(2, 0);
        load_bank(r0, r1);
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            for (int k = 0; k < T; k++) tv[k] = k + 1 - j;
            push_win();
        end
        @(negedge clk);
        valid_in = 1'b0;
        repeat (8) @(negedge clk);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL b2b_missing: want cyc %0d data %h", e.cyc, e.d); end
            else begin
                o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.d !== e.d) begin errors++; $display("FAIL b2b_data: got cyc %0d %h want cyc %0d %h", o.cyc, o.d, e.cyc, e.d); end
            end
        end
        obs_q.delete();
    endtask

    task automatic test_reload_stream();
        logic r0, r1;
        rec_t e, o;
        set_ld(0, 0);
        load_bank(r0, r1);
        set_ld(1, 0);
        for (int k = 0; k < T; k++) tv[k] = k + 1;
        // Restart at word 10; the last of 18 fresh words lands in slot 29, COMMIT is slot 30.
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            wt_load_start = (i == 0 || i == 11);
            wt_valid = 1'b0;
            if (i >= 1 && i <= 11) begin wt_valid = 1'b1; wt_data = pack_word(i - 1); end
            if (i >= 12 && i <= 29) begin wt_valid = 1'b1; wt_data = pack_word(i - 12); end
            push_win();
            if (i == 30) begin cur_w = ld_w; cur_b = ld_b; end
        end
        @(negedge clk);
        valid_in = 1'b0; wt_load_start = 1'b0; wt_valid = 1'b0;
        repeat (8) @(negedge clk);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL reload_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL reload_missing: want cyc %0d data %h", e.cyc, e.d); end
            else begin
                o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.d !== e.d) begin errors++; $display("FAIL reload_data: got cyc %0d %h want cyc %0d %h", o.cyc, o.d, e.cyc, e.d); end
            end
        end
        obs_q.delete();
    endtask

    task automatic test_async_reset();
        obs_q.delete();
        for (int k = 0; k < T; k++) tv[k] = k + 1;
        @(negedge clk);
        win_in = mk_win(); valid_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        #2 rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (8) @(negedge clk);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL arst_flush: got %0d outputs want 0", obs_q.size()); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL arst_valid_out: got %b want 0", valid_out); end
        checks++; if (wt_ready !== 1'b0) begin errors++; $display("FAIL arst_wt_ready: got %b want 0", wt_ready); end
        checks++; if (err_drop !== 1'b0) begin errors++; $display("FAIL arst_err_drop: got %b want 0", err_drop); end
        checks++; if (data_out !== '0) begin errors++; $display("FAIL arst_data_out: got %h want 0", data_out); end
        obs_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_no_weights();
        test_load();
        test_saturation();
        test_rounding();
        test_back_to_back();
        test_reload_stream();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
